sram_ctrl: RTL and testbench

- Sits directly downstream of the address-translation stage and drives the single off-chip 1M x 32 asynchronous SRAM.
- Accepts one data op plus one instruction fetch per transaction and serializes them onto the SRAM bus: data access first, then the fetch.
- Returns the raw load word and the fetched instruction.
- Pulses `success_o` once both accesses finish; this releases the pipeline stall.

---
 rtl/sram_ctrl_pkg.sv | 36 +++
 rtl/sram_ctrl_if.sv | 38 +++
 rtl/sram_store_lane.sv | 33 +++
 rtl/sram_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM controller: memory-op encodings, byte-enable
// patterns, the controller state encoding and op classification helpers.
package sram_ctrl_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [3:0] SRAM_BE_ALL  = 4'b0000;
  localparam logic [3:0] SRAM_BE_NONE = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    D_RD,
    D_WS,
    D_WP,
    D_WH,
    I_RD,
    DONE
  } sram_state_e;

  function automatic logic isLoadOp(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic isStoreOp(input logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response bundle between the address-translation stage (master)
// and the SRAM controller (slave).
interface sram_ctrl_if #(
  parameter int ADDR_W = 20
);

  logic [3:0]        ram_op_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [1:0]        bytes_i;
  logic [31:0]       store_data_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [31:0]       load_data_o;
  logic [31:0]       load_inst_o;
  logic              success_o;

  modport master (
    output ram_op_i,
    output data_addr_i,
    output bytes_i,
    output store_data_i,
    output inst_addr_i,
    input  load_data_o,
    input  load_inst_o,
    input  success_o
  );

  modport slave (
    input  ram_op_i,
    input  data_addr_i,
    input  bytes_i,
    input  store_data_i,
    input  inst_addr_i,
    output load_data_o,
    output load_inst_o,
    output success_o
  );

endinterface

// File: rtl/sram_store_lane.sv
// Store lane steering: turns a store op and byte offset into active-low byte
// enables and the lane-replicated write word. Non-store ops enable no lanes.
module sram_store_lane
  import sram_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  bytes_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  be_n_o,
  output logic [31:0] lane_data_o
);

  always_comb begin
    be_n_o      = SRAM_BE_NONE;
    lane_data_o = store_data_i;
    case (op_i)
      MEM_SB: begin
        be_n_o      = ~(4'b0001 << bytes_i);
        lane_data_o = {4{store_data_i[7:0]}};
      end
      MEM_SH: begin
        // Only bytes_i[1] selects the half; an odd offset is not an error here.
        be_n_o      = bytes_i[1] ? 4'b0011 : 4'b1100;
        lane_data_o = {2{store_data_i[15:0]}};
      end
      MEM_SW: begin
        be_n_o = SRAM_BE_ALL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: serializes one data access and one
// instruction fetch per transaction, then pulses success_o to release the stall.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        req,
  output logic [ADDR_W-1:0] sram_addr_o,
  inout  wire  [31:0]       sram_data_io,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);

  sram_state_e       state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] dataAddr_q, dataAddr_d;
  logic [ADDR_W-1:0] instAddr_q, instAddr_d;
  logic [3:0]        wrBe_q, wrBe_d;
  logic [31:0]       wrData_q, wrData_d;
  logic [31:0]       loadData_q, loadData_d;
  logic [31:0]       loadInst_q, loadInst_d;
  logic              success_q, success_d;
  logic              ceN_q, ceN_d;
  logic              oeN_q, oeN_d;
  logic              weN_q, weN_d;
  logic              drive_q, drive_d;
  logic [3:0]        beN_q, beN_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        laneBe;
  logic [31:0]       laneData;

  sram_store_lane u_store_lane (
    .op_i         (req.ram_op_i),
    .bytes_i      (req.bytes_i),
    .store_data_i (req.store_data_i),
    .be_n_o       (laneBe),
    .lane_data_o  (laneData)
  );

  // Sequencing: every phase that can stretch reloads the wait counter on entry
  // and leaves once it has counted down to zero.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    dataAddr_d = dataAddr_q;
    instAddr_d = instAddr_q;
    wrBe_d     = wrBe_q;
    wrData_d   = wrData_q;
    loadData_d = loadData_q;
    loadInst_d = loadInst_q;
    case (state_q)
      IDLE: begin
        dataAddr_d = req.data_addr_i;
        instAddr_d = req.inst_addr_i;
        wrBe_d     = laneBe;
        wrData_d   = laneData;
        wait_d     = WAIT_INIT;
        if (isLoadOp(req.ram_op_i)) begin
          state_d = D_RD;
        end else if (isStoreOp(req.ram_op_i)) begin
          state_d = D_WS;
        end else begin
          state_d = I_RD;
        end
      end
      D_RD: begin
        if (wait_q == 2'd0) begin
          loadData_d = sram_data_io;
          wait_d     = WAIT_INIT;
          state_d    = I_RD;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      D_WS: begin
        wait_d  = WAIT_INIT;
        state_d = D_WP;
      end
      D_WP: begin
        if (wait_q == 2'd0) begin
          state_d = D_WH;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      D_WH: begin
        wait_d  = WAIT_INIT;
        state_d = I_RD;
      end
      I_RD: begin
        if (wait_q == 2'd0) begin
          loadInst_d = sram_data_io;
          state_d    = DONE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so the registered pins line up
  // with the state they belong to; addresses use the freshly sampled request.
  always_comb begin
    ceN_d     = 1'b1;
    oeN_d     = 1'b1;
    weN_d     = 1'b1;
    drive_d   = 1'b0;
    beN_d     = SRAM_BE_NONE;
    addr_d    = addr_q;
    success_d = 1'b0;
    case (state_d)
      D_RD: begin
        ceN_d  = 1'b0;
        oeN_d  = 1'b0;
        beN_d  = SRAM_BE_ALL;
        addr_d = dataAddr_d;
      end
      D_WS, D_WH: begin
        ceN_d   = 1'b0;
        drive_d = 1'b1;
        beN_d   = wrBe_d;
        addr_d  = dataAddr_d;
      end
      D_WP: begin
        ceN_d   = 1'b0;
        weN_d   = 1'b0;
        drive_d = 1'b1;
        beN_d   = wrBe_d;
        addr_d  = dataAddr_d;
      end
      I_RD: begin
        ceN_d  = 1'b0;
        oeN_d  = 1'b0;
        beN_d  = SRAM_BE_ALL;
        addr_d = instAddr_d;
      end
      DONE: begin
        success_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_q     <= 2'd0;
      dataAddr_q <= '0;
      instAddr_q <= '0;
      wrBe_q     <= SRAM_BE_NONE;
      wrData_q   <= 32'd0;
      loadData_q <= 32'd0;
      loadInst_q <= 32'd0;
      success_q  <= 1'b0;
      ceN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      weN_q      <= 1'b1;
      drive_q    <= 1'b0;
      beN_q      <= SRAM_BE_NONE;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      dataAddr_q <= dataAddr_d;
      instAddr_q <= instAddr_d;
      wrBe_q     <= wrBe_d;
      wrData_q   <= wrData_d;
      loadData_q <= loadData_d;
      loadInst_q <= loadInst_d;
      success_q  <= success_d;
      ceN_q      <= ceN_d;
      oeN_q      <= oeN_d;
      weN_q      <= weN_d;
      drive_q    <= drive_d;
      beN_q      <= beN_d;
      addr_q     <= addr_d;
    end
  end

  assign sram_data_io    = drive_q ? wrData_q : 32'bz;
  assign sram_addr_o     = addr_q;
  assign sram_be_n_o     = beN_q;
  assign sram_ce_n_o     = ceN_q;
  assign sram_oe_n_o     = oeN_q;
  assign sram_we_n_o     = weN_q;
  assign req.load_data_o = loadData_q;
  assign req.load_inst_o = loadInst_q;
  assign req.success_o   = success_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a small SRAM model behind a zero-wait instance
// plus a read-only view behind a WAIT_CYCLES=2 instance.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(20)) if1 ();
  sram_ctrl_if #(.ADDR_W(20)) if2 ();

  wire  [31:0] bus1;
  wire  [31:0] bus2;
  logic [19:0] addr1, addr2;
  logic [3:0]  be1, be2;
  logic        ce1, oe1, we1, ce2, oe2, we2;

  logic [31:0] mem [0:255];
  logic        memReady = 1'b0;
  logic        tbDrive;

  sram_ctrl #(.WAIT_CYCLES(0), .ADDR_W(20)) dut1 (
    .clk(clk), .rst(rst), .req(if1),
    .sram_addr_o(addr1), .sram_data_io(bus1), .sram_be_n_o(be1),
    .sram_ce_n_o(ce1), .sram_oe_n_o(oe1), .sram_we_n_o(we1)
  );

  sram_ctrl #(.WAIT_CYCLES(2), .ADDR_W(20)) dut2 (
    .clk(clk), .rst(rst), .req(if2),
    .sram_addr_o(addr2), .sram_data_io(bus2), .sram_be_n_o(be2),
    .sram_ce_n_o(ce2), .sram_oe_n_o(oe2), .sram_we_n_o(we2)
  );

  assign bus1 = (!ce1 && !oe1 && we1) ? mem[addr1[7:0]] : (tbDrive ? 32'h5A5A5A5A : 32'bz);
  assign bus2 = (!ce2 && !oe2 && we2) ? mem[addr2[7:0]] : 32'bz;

  // SRAM array: preloaded once, then written per enabled byte while we_n is low.
  always @(negedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h04] <= 32'hDEADBEEF;
      mem[8'h08] <= 32'h11223344;
      mem[8'h0C] <= 32'h0;
      mem[8'h10] <= 32'h2402000A;
      mem[8'h11] <= 32'h8C430004;
      memReady   <= 1'b1;
    end else if (!ce1 && !we1) begin
      for (int b = 0; b < 4; b++)
        if (!be1[b]) mem[addr1[7:0]][b*8 +: 8] <= bus1[b*8 +: 8];
    end
  end

  int checkCount = 0;
  int passCount  = 0;
  int lat;
  int oeCycles, weCycles;
  logic [3:0]  beSeen;
  logic [31:0] busSeen;
  logic [19:0] addrSeen;
  logic [63:0] ceTrace, weTrace;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task applyStimulus(input logic [3:0] op, input logic [19:0] dAddr, input logic [1:0] bytes,
                     input logic [31:0] sData, input logic [19:0] iAddr);
    if1.ram_op_i     = op;
    if1.data_addr_i  = dAddr;
    if1.bytes_i      = bytes;
    if1.store_data_i = sData;
    if1.inst_addr_i  = iAddr;
  endtask

  // Waits for IDLE, then counts cycles after the sample edge; lat is the index
  // of the cycle in which success_o is high (-1 if it never comes).
  task runTxn(input logic [3:0] op, input logic [19:0] dAddr, input logic [1:0] bytes,
              input logic [31:0] sData, input logic [19:0] iAddr);
    int guard;
    applyStimulus(op, dAddr, bytes, sData, iAddr);
    guard = 0;
    while (!(ce1 == 1'b1 && if1.success_o == 1'b0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    lat = -1; oeCycles = 0; weCycles = 0;
    beSeen = 4'hF; busSeen = 32'h0; addrSeen = 20'h0;
    ceTrace = '1; weTrace = '1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      ceTrace[k] = ce1;
      weTrace[k] = we1;
      if (!oe1) oeCycles++;
      if (!we1) begin
        weCycles++;
        beSeen   = be1;
        busSeen  = bus1;
        addrSeen = addr1;
      end
      if (if1.success_o) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    tbDrive = 1'b0;
    applyStimulus(MEM_NOP, 20'h0, 2'd0, 32'h0, 20'h0);
    if2.ram_op_i = MEM_NOP; if2.data_addr_i = 20'h0; if2.bytes_i = 2'd0;
    if2.store_data_i = 32'h0; if2.inst_addr_i = 20'h0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ce_n", ce1, 1'b1);
    checkOutput("rst_oe_n", oe1, 1'b1);
    checkOutput("rst_we_n", we1, 1'b1);
    checkOutput("rst_be_n", be1, 4'hF);
    checkOutput("rst_addr", addr1, 20'h0);
    checkOutput("rst_load_data", if1.load_data_o, 32'h0);
    checkOutput("rst_load_inst", if1.load_inst_o, 32'h0);
    checkOutput("rst_success", if1.success_o, 1'b0);
    rst = 1'b1;

    runTxn(MEM_NOP, 20'h0, 2'd0, 32'h0, 20'h10);
    checkOutput("nop_latency", lat, 2);
    checkOutput("nop_inst", if1.load_inst_o, 32'h2402000A);
    checkOutput("nop_one_read_cycle", oeCycles, 1);
    checkOutput("nop_no_write", weCycles, 0);
    checkOutput("nop_data_kept", if1.load_data_o, 32'h0);
    @(negedge clk);
    checkOutput("success_one_cycle", if1.success_o, 1'b0);

    runTxn(MEM_LW, 20'h4, 2'd0, 32'h0, 20'h11);
    checkOutput("lw_latency", lat, 3);
    checkOutput("lw_data", if1.load_data_o, 32'hDEADBEEF);
    checkOutput("lw_inst", if1.load_inst_o, 32'h8C430004);

    runTxn(MEM_SB, 20'h4, 2'd2, 32'h000000A5, 20'h10);
    checkOutput("sb_latency", lat, 5);
    checkOutput("sb_be_n", beSeen, 4'b1011);
    checkOutput("sb_bus", busSeen, 32'hA5A5A5A5);
    checkOutput("sb_addr", addrSeen, 20'h4);
    checkOutput("sb_we_cycles", weCycles, 1);
    checkOutput("sb_setup", {ceTrace[1], weTrace[1]}, 2'b01);
    checkOutput("sb_strobe", {ceTrace[2], weTrace[2]}, 2'b00);
    checkOutput("sb_hold", {ceTrace[3], weTrace[3]}, 2'b01);
    checkOutput("sb_data_kept", if1.load_data_o, 32'hDEADBEEF);
    checkOutput("sb_inst", if1.load_inst_o, 32'h2402000A);

    runTxn(MEM_LW, 20'h4, 2'd0, 32'h0, 20'h10);
    checkOutput("sb_readback", if1.load_data_o, 32'hDEA5BEEF);

    runTxn(MEM_SH, 20'h8, 2'd3, 32'h1234BEEF, 20'h10);
    checkOutput("sh_hi_be_n", beSeen, 4'b0011);
    checkOutput("sh_hi_bus", busSeen, 32'hBEEFBEEF);
    runTxn(MEM_LW, 20'h8, 2'd0, 32'h0, 20'h10);
    checkOutput("sh_hi_readback", if1.load_data_o, 32'hBEEF3344);

    runTxn(MEM_SH, 20'h8, 2'd1, 32'hFFFF5566, 20'h10);
    checkOutput("sh_lo_be_n", beSeen, 4'b1100);
    checkOutput("sh_lo_bus", busSeen, 32'h55665566);
    runTxn(MEM_LW, 20'h8, 2'd0, 32'h0, 20'h10);
    checkOutput("sh_lo_readback", if1.load_data_o, 32'hBEEF5566);

    runTxn(MEM_SW, 20'hC, 2'd1, 32'hCAFEF00D, 20'h10);
    checkOutput("sw_be_n", beSeen, 4'b0000);
    checkOutput("sw_bus", busSeen, 32'hCAFEF00D);
    runTxn(MEM_SB, 20'hC, 2'd0, 32'h12345677, 20'h10);
    checkOutput("sb0_be_n", beSeen, 4'b1110);
    runTxn(MEM_LW, 20'hC, 2'd0, 32'h0, 20'h11);
    checkOutput("sw_sb_readback", if1.load_data_o, 32'hCAFEF077);

    runTxn(4'hF, 20'h4, 2'd0, 32'h0, 20'h10);
    checkOutput("undef_latency", lat, 2);
    checkOutput("undef_no_write", weCycles, 0);
    checkOutput("undef_data_kept", if1.load_data_o, 32'hCAFEF077);

    // Reset in the middle of the write strobe.
    applyStimulus(MEM_SW, 20'h20, 2'd0, 32'h0BADF00D, 20'h10);
    guard = 0;
    while (!(ce1 == 1'b1 && if1.success_o == 1'b0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    guard = 0;
    while (we1 !== 1'b0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("wp_reached", we1, 1'b0);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_async_we_n", we1, 1'b1);
    checkOutput("rst_async_ce_n", ce1, 1'b1);
    tbDrive = 1'b1;
    #1;
    checkOutput("rst_bus_released", bus1, 32'h5A5A5A5A);
    tbDrive = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_no_success", if1.success_o, 1'b0);
    end
    applyStimulus(MEM_NOP, 20'h0, 2'd0, 32'h0, 20'h10);
    if2.ram_op_i = MEM_LW; if2.data_addr_i = 20'h4; if2.inst_addr_i = 20'h11;
    rst = 1'b1;
    #1;
    checkOutput("post_rst_idle", {ce1, oe1, we1, if1.success_o}, 4'b1110);
    checkOutput("post_rst_be_n", be1, 4'hF);
    checkOutput("post_rst_addr", addr1, 20'h0);
    checkOutput("post_rst_data", if1.load_data_o, 32'h0);
    checkOutput("post_rst_inst", if1.load_inst_o, 32'h0);

    // WAIT_CYCLES=2 instance: first posedge after release samples the LW.
    @(posedge clk);
    lat = -1;
    oeCycles = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if2.ram_op_i = MEM_LB; if2.data_addr_i = 20'h8; if2.inst_addr_i = 20'h10;
      end
      if (!oe2 && addr2 == 20'h4) oeCycles++;
      if (if2.success_o) begin
        lat = k;
        break;
      end
    end
    checkOutput("wait2_data_read_cycles", oeCycles, 3);
    checkOutput("wait2_latency", lat, 7);
    checkOutput("wait2_data", if2.load_data_o, 32'hDEA5BEEF);
    checkOutput("wait2_inst", if2.load_inst_o, 32'h8C430004);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
